// File: rtl/dm_lsu_pkg.sv
// dm_lsu_pkg: shared encodings for the load/store unit.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package dm_lsu_pkg;

  // Access size codes as presented on size_i. Bit 2 selects zero-extension on
  // loads. Bits 1:0 select the lane width (00 byte, 01 half, 1x word).
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // True when the byte offset does not match the natural alignment of the size.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
    logic r;
    case (size[1:0])
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      default: r = (off != 2'b00);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_lsu_lane.sv
// dm_lsu_lane: byte/half lane merge for stores and lane extract/extend for loads.
// Latency: purely combinational.
// Backpressure: none; pure function of its inputs.
// Ports: old_word_i (current memory word), wdata_i (store data, low bits used),
//        size_i (size code), off_i (byte offset), merged_o (word to write back),
//        rdata_o (extended load result).
module dm_lsu_lane
  import dm_lsu_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    merged_o = old_word_i;
    if (size_i[1:0] == SZ_B[1:0]) begin
      case (off_i)
        2'd0:    merged_o[7:0]   = wdata_i[7:0];
        2'd1:    merged_o[15:8]  = wdata_i[7:0];
        2'd2:    merged_o[23:16] = wdata_i[7:0];
        default: merged_o[31:24] = wdata_i[7:0];
      endcase
    end else if (size_i[1:0] == SZ_H[1:0]) begin
      // off_i[0] is ignored: half lanes are chosen by off_i[1] only.
      if (off_i[1]) merged_o[31:16] = wdata_i[15:0];
      else          merged_o[15:0]  = wdata_i[15:0];
    end else begin
      merged_o = wdata_i;
    end
  end

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = old_word_i[7:0];
      2'd1:    byte_sel = old_word_i[15:8];
      2'd2:    byte_sel = old_word_i[23:16];
      default: byte_sel = old_word_i[31:24];
    endcase
    half_sel = off_i[1] ? old_word_i[31:16] : old_word_i[15:0];
    sext     = ~size_i[2];
    // Codes 011/110/111 fall into the default branch and load a full word.
    case (size_i[1:0])
      2'b00:   rdata_o = {{24{sext & byte_sel[7]}}, byte_sel};
      2'b01:   rdata_o = {{16{sext & half_sel[15]}}, half_sel};
      default: rdata_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: load/store unit driving a word-only Data_mem, with RMW for sb/sh.
// Latency: request cycle to done_o is 2 for loads and sw, 3 for sb/sh (1 on a trapped misalignment).
// Backpressure: stall_o = req_i & ~done_o holds the core; req_i must stay high until done_o.
// Ports: core side req_i/we_i/size_i/addr_i/wdata_i in, rdata_o/done_o/stall_o/err_o out;
//        memory side DM_A/DM_WD/DM_WE out, DM_RD in (combinational read).
// Option: define DM_LSU_MISALIGN_TRAP_EN to complete misaligned half/word accesses
//         immediately with err_o and no memory access; otherwise err_o is 0.
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DM_AW  = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              stall_o,
  output logic              err_o,
  output logic [DM_AW-1:0]  DM_A,
  output logic [31:0]       DM_WD,
  output logic              DM_WE,
  input  logic [31:0]       DM_RD
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          size_q;
  logic                we_q;
  logic [31:0]         wdata_q;
  logic [31:0]         merged_q;
  logic [31:0]         rdata_q;
  logic [31:0]         lane_merged;
  logic [31:0]         lane_rdata;
  logic [ADDR_W-1:0]   word_idx;
  logic                accept;

  assign accept   = (state_q == IDLE) && req_i;
  assign word_idx = addr_q >> 2;

  dm_lsu_lane u_lane (
    .old_word_i (DM_RD),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .off_i      (addr_q[1:0]),
    .merged_o   (lane_merged),
    .rdata_o    (lane_rdata)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
`ifdef DM_LSU_MISALIGN_TRAP_EN
          state_d = misaligned(size_i, addr_i[1:0]) ? DONE : ACCESS;
`else
          state_d = ACCESS;
`endif
        end
      end
      // Sub-word stores need a second cycle to write back the merged word.
      ACCESS:  state_d = (we_q && !size_q[1]) ? WRITE : DONE;
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Request latches, merge buffer and load result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q   <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr_i;
        size_q  <= size_i;
        we_q    <= we_i;
        wdata_q <= wdata_i;
      end
      if (state_q == ACCESS) begin
        merged_q <= lane_merged;
        if (!we_q) rdata_q <= lane_rdata;
      end
    end
  end

`ifdef DM_LSU_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      err_q <= 1'b0;
    else if (accept) err_q <= misaligned(size_i, addr_i[1:0]);
  end
  assign err_o = done_o & err_q;
`else
  assign err_o = 1'b0;
`endif

  // Outputs, decoded from the registered state so reset drops DM_WE at once.
  always_comb begin
    done_o  = (state_q == DONE);
    DM_WE   = ((state_q == ACCESS) && we_q && size_q[1]) || (state_q == WRITE);
    DM_WD   = (state_q == WRITE) ? merged_q : wdata_q;
    DM_A    = DM_AW'(word_idx);
    rdata_o = rdata_q;
    stall_o = req_i & ~done_o;
  end

endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: directed self-checking bench for dm_lsu with a small word memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dm_lsu;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_i;
  logic        we_i;
  logic [2:0]  size_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        stall_o;
  logic        err_o;
  logic [31:0] DM_A;
  logic [31:0] DM_WD;
  logic        DM_WE;
  logic [31:0] DM_RD;

  int total = 0;
  int bad   = 0;

  // Memory model: combinational read, write on rising edge; preload port for the bench.
  logic [31:0] mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;

  assign DM_RD = mem[DM_A[3:0]];

  always @(posedge CLK) begin
    if (DM_WE)      mem[DM_A[3:0]] <= DM_WD;
    else if (pl_en) mem[pl_idx]    <= pl_val;
  end

  always #5 CLK = ~CLK;

  dm_lsu #(.ADDR_W(32), .DM_AW(32)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .req_i   (req_i),
    .we_i    (we_i),
    .size_i  (size_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .done_o  (done_o),
    .stall_o (stall_o),
    .err_o   (err_o),
    .DM_A    (DM_A),
    .DM_WD   (DM_WD),
    .DM_WE   (DM_WE),
    .DM_RD   (DM_RD)
  );

  // Observations of the last operation.
  int          lat;
  int          we_cnt;
  logic [31:0] we_a;
  logic [31:0] we_wd;
  logic [31:0] a_c1;
  logic        stall_c1;
  logic        err_done;

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_en  = 1'b1;
    @(posedge CLK); #1;
    pl_en  = 1'b0;
  endtask

  // Issues one request; inputs are scrambled after acceptance to show they are ignored.
  task automatic run_op(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic hold_req);
    req_i = 1'b1; we_i = we; size_i = sz; addr_i = a; wdata_i = wd;
    lat = 99; we_cnt = 0; we_a = '0; we_wd = '0; a_c1 = '0; stall_c1 = 1'b0; err_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge CLK); #1;
      if (c == 1) begin
        a_c1     = DM_A;
        stall_c1 = stall_o;
        addr_i   = 32'hFFFF_FFFC;
        wdata_i  = 32'hDEAD_BEEF;
      end
      if (DM_WE) begin
        we_cnt++;
        we_a  = DM_A;
        we_wd = DM_WD;
      end
      if (done_o) begin
        lat      = c;
        err_done = err_o;
        break;
      end
    end
    if (!hold_req) begin
      req_i = 1'b0;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 3'b0; addr_i = '0; wdata_i = '0;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", rdata_o, 32'h0); end
    total++; if (done_o !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
    total++; if (err_o !== 1'b0)    begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
    total++; if (DM_A !== 32'h0)    begin bad++; $display("FAIL reset_dm_a got=%h exp=0", DM_A); end
    total++; if (DM_WD !== 32'h0)   begin bad++; $display("FAIL reset_dm_wd got=%h exp=0", DM_WD); end
    total++; if (DM_WE !== 1'b0)    begin bad++; $display("FAIL reset_dm_we got=%b exp=0", DM_WE); end
    total++; if (stall_o !== 1'b0)  begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_lw;
    poke(4'd2, 32'h8899_AABB);
    run_op(1'b0, 3'b010, 32'h8, 32'h0, 1'b0);
    total++; if (a_c1 !== 32'd2)          begin bad++; $display("FAIL lw_dm_a got=%h exp=%h", a_c1, 32'd2); end
    total++; if (lat != 2)                begin bad++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    total++; if (rdata_o !== 32'h8899AABB) begin bad++; $display("FAIL lw_rdata got=%h exp=8899aabb", rdata_o); end
    total++; if (we_cnt != 0)             begin bad++; $display("FAIL lw_no_write got=%0d exp=0", we_cnt); end
    total++; if (stall_c1 !== 1'b1)       begin bad++; $display("FAIL lw_stall got=%b exp=1", stall_c1); end
    total++; if (err_done !== 1'b0)       begin bad++; $display("FAIL lw_err got=%b exp=0", err_done); end
  endtask

  task automatic test_sw;
    poke(4'd0, 32'h0);
    run_op(1'b1, 3'b010, 32'h0, 32'hFFFF_FFFF, 1'b0);
    total++; if (lat != 2)                   begin bad++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    total++; if (we_cnt != 1)                begin bad++; $display("FAIL sw_we_cycles got=%0d exp=1", we_cnt); end
    total++; if (we_a !== 32'h0)             begin bad++; $display("FAIL sw_dm_a got=%h exp=0", we_a); end
    total++; if (mem[0] !== 32'hFFFF_FFFF)   begin bad++; $display("FAIL sw_mem got=%h exp=ffffffff", mem[0]); end
    total++; if (rdata_o !== 32'h8899AABB)   begin bad++; $display("FAIL sw_rdata_held got=%h exp=8899aabb", rdata_o); end
    run_op(1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
    total++; if (rdata_o !== 32'hFFFF_FFFF)  begin bad++; $display("FAIL sw_readback got=%h exp=ffffffff", rdata_o); end
  endtask

  task automatic test_sb_sh;
    poke(4'd1, 32'h1122_3344);
    run_op(1'b1, 3'b000, 32'h5, 32'hAAAA_AA5A, 1'b0);
    total++; if (lat != 3)                  begin bad++; $display("FAIL sb_latency got=%0d exp=3", lat); end
    total++; if (we_cnt != 1)               begin bad++; $display("FAIL sb_we_cycles got=%0d exp=1", we_cnt); end
    total++; if (we_wd !== 32'h1122_5A44)   begin bad++; $display("FAIL sb_dm_wd got=%h exp=11225a44", we_wd); end
    total++; if (mem[1] !== 32'h1122_5A44)  begin bad++; $display("FAIL sb_mem got=%h exp=11225a44", mem[1]); end
    total++; if (rdata_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sb_rdata_held got=%h exp=ffffffff", rdata_o); end
    run_op(1'b1, 3'b001, 32'h6, 32'h5555_BEEF, 1'b0);
    total++; if (mem[1] !== 32'hBEEF_5A44)  begin bad++; $display("FAIL sh_hi_mem got=%h exp=beef5a44", mem[1]); end
    run_op(1'b1, 3'b000, 32'h4, 32'h0000_0077, 1'b0);
    total++; if (mem[1] !== 32'hBEEF_5A77)  begin bad++; $display("FAIL sb_b0_mem got=%h exp=beef5a77", mem[1]); end
  endtask

  task automatic test_extend;
    poke(4'd1, 32'h8000_0000);
    run_op(1'b0, 3'b000, 32'h7, 32'h0, 1'b0);
    total++; if (rdata_o !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb got=%h exp=ffffff80", rdata_o); end
    run_op(1'b0, 3'b100, 32'h7, 32'h0, 1'b0);
    total++; if (rdata_o !== 32'h0000_0080) begin bad++; $display("FAIL lbu got=%h exp=00000080", rdata_o); end
    run_op(1'b0, 3'b001, 32'h6, 32'h0, 1'b0);
    total++; if (rdata_o !== 32'hFFFF_8000) begin bad++; $display("FAIL lh got=%h exp=ffff8000", rdata_o); end
    run_op(1'b0, 3'b101, 32'h6, 32'h0, 1'b0);
    total++; if (rdata_o !== 32'h0000_8000) begin bad++; $display("FAIL lhu got=%h exp=00008000", rdata_o); end
    poke(4'd3, 32'h0000_7F81);
    run_op(1'b0, 3'b001, 32'hC, 32'h0, 1'b0);
    total++; if (rdata_o !== 32'h0000_7F81) begin bad++; $display("FAIL lh_pos got=%h exp=00007f81", rdata_o); end
    run_op(1'b0, 3'b111, 32'hC, 32'h0, 1'b0);
    total++; if (rdata_o !== 32'h0000_7F81) begin bad++; $display("FAIL l111_word got=%h exp=00007f81", rdata_o); end
  endtask

  task automatic test_back_to_back;
    run_op(1'b0, 3'b010, 32'h8, 32'h0, 1'b1);
    total++; if (rdata_o !== 32'h8899AABB) begin bad++; $display("FAIL b2b_rdata got=%h exp=8899aabb", rdata_o); end
    // req_i still high through DONE: next cycle must be IDLE, not a new access.
    @(posedge CLK); #1;
    total++; if (done_o !== 1'b0)  begin bad++; $display("FAIL b2b_done_once got=%b exp=0", done_o); end
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL b2b_stall got=%b exp=1", stall_o); end
    req_i = 1'b0;
    run_op(1'b1, 3'b010, 32'h8, 32'h0102_0304, 1'b0);
    total++; if (lat != 2)                 begin bad++; $display("FAIL b2b_sw_latency got=%0d exp=2", lat); end
    total++; if (mem[2] !== 32'h0102_0304) begin bad++; $display("FAIL b2b_sw_mem got=%h exp=01020304", mem[2]); end
  endtask

  task automatic test_reset_mid_write;
    poke(4'd1, 32'h1122_3344);
    req_i = 1'b1; we_i = 1'b1; size_i = 3'b001; addr_i = 32'h6; wdata_i = 32'h0000_BEEF;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    total++; if (DM_WE !== 1'b1)          begin bad++; $display("FAIL rst_write_we got=%b exp=1", DM_WE); end
    total++; if (DM_WD !== 32'hBEEF_3344) begin bad++; $display("FAIL rst_write_wd got=%h exp=beef3344", DM_WD); end
    RST_N = 1'b0;
    #1;
    total++; if (DM_WE !== 1'b0)          begin bad++; $display("FAIL rst_we_drop got=%b exp=0", DM_WE); end
    @(posedge CLK); #1;
    total++; if (mem[1] !== 32'h1122_3344) begin bad++; $display("FAIL rst_mem_kept got=%h exp=11223344", mem[1]); end
    RST_N = 1'b1;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL rst_stall_req got=%b exp=1", stall_o); end
    total++; if (done_o !== 1'b0)  begin bad++; $display("FAIL rst_done got=%b exp=0", done_o); end
    req_i = 1'b0;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall_idle got=%b exp=0", stall_o); end
    @(posedge CLK); #1;
  endtask

  task automatic test_misalign;
    poke(4'd0, 32'h0A0B_0C0D);
    poke(4'd3, 32'h1234_5678);
    run_op(1'b0, 3'b010, 32'hC, 32'h0, 1'b0);
    run_op(1'b0, 3'b010, 32'h3, 32'h0, 1'b0);
`ifdef DM_LSU_MISALIGN_TRAP_EN
    total++; if (lat != 1)                  begin bad++; $display("FAIL mis_latency got=%0d exp=1", lat); end
    total++; if (err_done !== 1'b1)         begin bad++; $display("FAIL mis_err got=%b exp=1", err_done); end
    total++; if (we_cnt != 0)               begin bad++; $display("FAIL mis_no_write got=%0d exp=0", we_cnt); end
    total++; if (rdata_o !== 32'h1234_5678) begin bad++; $display("FAIL mis_rdata_held got=%h exp=12345678", rdata_o); end
`else
    total++; if (lat != 2)                  begin bad++; $display("FAIL mis_latency got=%0d exp=2", lat); end
    total++; if (err_done !== 1'b0)         begin bad++; $display("FAIL mis_err got=%b exp=0", err_done); end
    total++; if (rdata_o !== 32'h0A0B_0C0D) begin bad++; $display("FAIL mis_rdata got=%h exp=0a0b0c0d", rdata_o); end
`endif
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL mis_err_after got=%b exp=0", err_o); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_sb_sh();
    test_extend();
    test_back_to_back();
    test_reset_mid_write();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_lsu.md
Name: dm_lsu

Overview:
- Load/store unit: the initiator side of the Data_mem port (CLK, A, WD, WE, RD).
- Accepts byte/half/word load and store requests from the core with a req/done handshake.
- Drives Data_mem word accesses and performs read-modify-write for sub-word stores, since Data_mem writes whole words only.
- Sits between the core execute stage and Data_mem; stalls the core until the access completes.

Parameters:
- ADDR_W, 32, width of core byte address addr_i.
- DM_AW, 32, width of DM_A word index driven to Data_mem.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- req_i  in  1  access request, held by core until done_o.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  32  store data, low bits used for sb/sh.
- rdata_o  out  32  registered, extended load result.
- done_o  out  1  one-cycle completion pulse.
- stall_o  out  1  core stall.
- err_o  out  1  misalignment flag; see Optional Feature.
- DM_A  out  DM_AW  Data_mem word index.
- DM_WD  out  32  Data_mem write data.
- DM_WE  out  1  Data_mem write enable.
- DM_RD  in  32  Data_mem combinational read data.

Behaviour:
- Interface:
  - One clock, CLK.
  - Reset RST_N is asynchronous and active-low.
- Reset values:
  - State IDLE.
  - rdata_o = 0, done_o = 0, err_o = 0.
  - DM_A = 0, DM_WD = 0, DM_WE = 0.
  - Internal address/size/data latches cleared.
- Data_mem model:
  - RD is combinational from A.
  - Write occurs at the rising CLK edge when WE = 1.
  - DM_A = addr >> 2.
- FSM states and transitions:
  - IDLE: on req_i, latch addr_i, size_i, we_i, wdata_i; go to ACCESS.
  - ACCESS: DM_A = latched index.
    - Load: sign/zero-extend the selected lane of DM_RD into rdata_o at the edge; go to DONE.
    - sw (size[1:0] = 10 or 11): DM_WE = 1, DM_WD = wdata; go to DONE.
    - sb/sh: merge wdata lane into DM_RD, register the result; go to WRITE.
  - WRITE: DM_WE = 1, DM_WD = merged word, same DM_A; go to DONE.
  - DONE: done_o = 1 for exactly this cycle; go to IDLE unconditionally. A held req_i is not re-accepted here.
- Latency, request cycle to done_o: load 2, sw 2, sb/sh 3.
- stall_o = req_i & ~done_o (combinational).
- DM_WE is high only in ACCESS (word store) or WRITE. Never in IDLE or DONE.
- Lane selection:
  - Byte: addr[1:0] selects the byte.
  - Half: addr[1] selects the half (0 = bits 15:0). addr[0] ignored.
  - Word: addr[1:0] ignored.
- Extension:
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Load codes 011/110/111 behave as lw.
  - Store uses size[1:0] only.
- rdata_o holds its value until the next load completes. Stores do not change it.
- Inputs are latched in IDLE only; changes to addr_i/wdata_i during an access are ignored.
- Reset mid-operation: DM_WE drops immediately (asynchronous); FSM returns to IDLE. A WRITE cut by reset writes nothing.

Optional Feature:
- Macro: DM_LSU_MISALIGN_TRAP_EN.
- Defined:
  - lh/lhu/sh with addr[0] = 1, or lw/sw with addr[1:0] != 0, goes IDLE -> DONE directly.
  - No Data_mem access; DM_WE stays 0.
  - err_o = 1 together with done_o; rdata_o unchanged.
- Undefined: err_o tied 0; misaligned addresses follow the lane rules above.

Decomposition:
- Package dm_lsu_pkg:
  - Size encodings SZ_B/SZ_H/SZ_W/SZ_BU/SZ_HU.
  - FSM state encoding IDLE/ACCESS/WRITE/DONE.
- Sub-module dm_lsu_lane (combinational):
  - Store merge: old word, wdata, size, offset -> new word.
  - Load extract/extend: word, size, offset -> rdata.

Test Plan:
- lw from word 2 holding 0x8899AABB; req at addr 0x8:
  - DM_A = 2 in ACCESS.
  - done_o in cycle 2; rdata_o = 0x8899AABB.
  - DM_WE never high.
- sw 0xFFFFFFFF to addr 0x0:
  - DM_WE = 1 for exactly one cycle with DM_A = 0.
  - done_o in cycle 2; a following lw of addr 0x0 returns 0xFFFFFFFF.
- sb 0x5A to addr 0x5, word 1 = 0x11223344:
  - WRITE cycle drives DM_WD = 0x11225A44.
  - done_o in cycle 3.
- lb/lbu at addr 0x7, word 1 = 0x80000000:
  - lb gives 0xFFFFFF80; lbu gives 0x00000080.
  - lh at addr 0x6 gives 0xFFFF8000.
- RST_N low during WRITE of an sh:
  - DM_WE falls immediately; memory word unchanged.
  - After release, FSM is IDLE and stall_o = req_i.
- With DM_LSU_MISALIGN_TRAP_EN, lw at addr 0x3:
  - done_o and err_o high in cycle 1; DM_WE = 0; rdata_o unchanged.
  - Without the macro: normal lw of word 0.
